// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces and emits one clean key event at a time
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] button,
    output logic       bstate,
    output logic       readInput,
    output logic       keyPulse
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Nibble i holds the code for row i/4, column i%4
    localparam logic [63:0] CODES = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
    state_t        state;
    logic [3:0]    rs1, rs, cand, code;
    logic [DW-1:0] dwell;
    logic [CW-1:0] db, db_next;
    logic [1:0]    ri, ci;
    logic          db_done, dwell_end;
    always_comb begin
        ri        = !cand[0] ? 2'd0 : !cand[1] ? 2'd1 : !cand[2] ? 2'd2 : 2'd3;
        ci        = !col[0] ? 2'd0 : !col[1] ? 2'd1 : !col[2] ? 2'd2 : 2'd3;
        code      = CODES[{ri, ci, 2'b00} +: 4];
        db_next   = (db == CW'(DEBOUNCE_CYCLES)) ? db : db + 1'b1;
        db_done   = db_next == CW'(DEBOUNCE_CYCLES);
        dwell_end = dwell == DW'(SCAN_DIV - 1);
    end
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            rs1       <= 4'hF;
            rs        <= 4'hF;
            cand      <= 4'hF;
            col       <= 4'b1110;
            dwell     <= '0;
            db        <= '0;
            button    <= '0;
            bstate    <= 1'b0;
            readInput <= 1'b0;
            keyPulse  <= 1'b0;
        end else begin
            rs1      <= row;
            rs       <= rs1;
            keyPulse <= 1'b0;
            // readInput trails the falling edge of bstate by one cycle
            if (!bstate) readInput <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_end) begin
                        dwell <= '0;
                        if ($onehot(~rs)) begin
                            cand  <= rs;
                            db    <= '0;
                            state <= PRESS_DB;
                        end else col <= {col[2:0], col[3]};
                    end else dwell <= dwell + 1'b1;
                end
                PRESS_DB: begin
                    if (rs == cand) begin
                        db <= db_next;
                        if (db_done) begin
                            button    <= code;
                            bstate    <= 1'b1;
                            readInput <= 1'b1;
                            keyPulse  <= 1'b1;
                            state     <= HELD;
                        end
                    end else begin
                        db    <= '0;
                        state <= SCAN;
                        col   <= {col[2:0], col[3]};
                    end
                end
                HELD: begin
                    if (&rs) begin
                        db    <= '0;
                        state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (&rs) begin
                        db <= db_next;
                        if (db_done) begin
                            bstate <= 1'b0;
                            state  <= SCAN;
                            col    <= {col[2:0], col[3]};
                        end
                    end else state <= HELD;
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus queue scoreboard for keypad_scanner
module tb_keypad_scanner;
    logic        hwclk = 1'b0, reset_n = 1'b0;
    logic [3:0]  row, col, button;
    logic        bstate, readInput, keyPulse;
    logic [15:0] keys = '0;
    logic        glitch = 1'b0;
    int          checks = 0, failures = 0, pulses = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  last_code = '0;
    logic        prev_b = 1'b0, prev_p = 1'b0;
    typedef struct {int r; int c; logic [3:0] code;} vec_t;
    vec_t seq[6];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(16)) dut (
        .hwclk(hwclk), .reset_n(reset_n), .row(row), .col(col),
        .button(button), .bstate(bstate), .readInput(readInput), .keyPulse(keyPulse)
    );

    always #5 hwclk = ~hwclk;

    // Pressed key (r,c) pulls row r low while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!glitch && keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge hwclk) begin
        if (keyPulse) begin
            pulses++;
            check("pulse_width", {31'b0, prev_p}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pulse with button %0d expected none", button);
            end else begin
                last_code = exp_q.pop_front();
                check("pulse_button", {28'b0, button}, {28'b0, last_code});
                check("pulse_bstate_readinput", {30'b0, bstate, readInput}, 3);
            end
        end
        if (prev_b && !bstate && reset_n) begin
            check("fall_button", {28'b0, button}, {28'b0, last_code});
            check("fall_readinput", {31'b0, readInput}, 1);
        end
        prev_b = bstate;
        prev_p = keyPulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge hwclk);
            n++;
        end
        check({name, "_accept"}, {31'b0, exp_q.size() == 0}, 1);
    endtask

    task automatic wait_release(input string name, output int n);
        n = 0;
        while (bstate && n < 100) begin
            @(negedge hwclk);
            n++;
        end
        check({name, "_release"}, {31'b0, bstate}, 0);
    endtask

    task automatic wait_col(output int n);
        logic [3:0] p = col;
        n = 0;
        while (col == p && n < 20) begin
            @(negedge hwclk);
            n++;
        end
    endtask

    initial begin
        int n, p0;
        logic [3:0] p;
        seq[0] = '{2, 2, 4'd9};
        seq[1] = '{0, 0, 4'd1};
        seq[2] = '{0, 1, 4'd2};
        seq[3] = '{0, 2, 4'd3};
        seq[4] = '{1, 0, 4'd4};
        seq[5] = '{2, 2, 4'd9};
        cycles(3);
        check("reset_col", {28'b0, col}, 4'b1110);
        check("reset_button", {28'b0, button}, 0);
        check("reset_flags", {29'b0, bstate, readInput, keyPulse}, 0);
        reset_n = 1'b1;
        cycles(2);

        // Single press r1c1 with release latency
        keys[5] = 1'b1;
        exp_q.push_back(4'd5);
        wait_accept("a");
        cycles(3);
        check("a_col_frozen", {28'b0, col}, 4'b1101);
        check("a_bstate", {31'b0, bstate}, 1);
        cycles(60);
        keys = '0;
        wait_release("a", n);
        check("a_release_latency", n, 19);
        @(negedge hwclk);
        check("a_readinput_fall", {31'b0, readInput}, 0);

        // Bouncing r2c1, then stable
        cycles(10);
        for (int i = 0; i < 12; i++) begin
            keys[9] = ~keys[9];
            cycles(5);
        end
        check("b_no_accept_bounce", {31'b0, bstate}, 0);
        keys[9] = 1'b1;
        exp_q.push_back(4'd8);
        wait_accept("b");
        keys = '0;
        wait_release("b", n);

        // Two keys in one column: rejected, scan keeps rotating
        cycles(10);
        keys[2] = 1'b1;
        keys[6] = 1'b1;
        wait_col(n);
        for (int i = 0; i < 5; i++) begin
            p = col;
            wait_col(n);
            check("c_col_rotate", {28'b0, col}, {28'b0, p[2:0], p[3]});
            check("c_dwell", n, 4);
        end
        check("c_no_accept", {31'b0, bstate}, 0);
        keys = '0;
        cycles(10);

        // Hold '#', short glitch high while held
        keys[14] = 1'b1;
        exp_q.push_back(4'd15);
        wait_accept("d");
        cycles(10);
        glitch = 1'b1;
        cycles(5);
        glitch = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge hwclk);
            check("d_bstate_held", {31'b0, bstate}, 1);
        end
        check("d_button", {28'b0, button}, 15);
        keys = '0;
        wait_release("d", n);

        // Reset while key held, then re-accept
        cycles(10);
        keys[0] = 1'b1;
        exp_q.push_back(4'd1);
        wait_accept("e");
        cycles(5);
        reset_n = 1'b0;
        #1;
        check("e_reset_flags", {29'b0, bstate, readInput, keyPulse}, 0);
        check("e_reset_button", {28'b0, button}, 0);
        check("e_reset_col", {28'b0, col}, 4'b1110);
        cycles(3);
        reset_n = 1'b1;
        exp_q.push_back(4'd1);
        wait_accept("e_reaccept");
        keys = '0;
        wait_release("e", n);

        // Key sequence 9,1,2,3,4,9
        p0 = pulses;
        foreach (seq[i]) begin
            cycles(10);
            keys[seq[i].r*4+seq[i].c] = 1'b1;
            exp_q.push_back(seq[i].code);
            wait_accept("f");
            cycles(20);
            keys = '0;
            wait_release("f", n);
        end
        cycles(3);
        check("f_pulse_count", pulses - p0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
